conv_tile_sched: RTL and testbench

Sequencer for the 3x3 RGB convolution datapath operating on a 6x6 tile buffer.
- Accepts a raster pixel stream under valid/ready and issues tile-buffer write addresses.
- After the tile is full, steps the 3x3 window origin over all valid positions under a valid/ready handshake to the convolution engine.
- Reports busy, done and a completed-frame count to the top-level control.

---
 rtl/conv_tile_sched.sv | 177 +++++++++++++++++
 tb/tb_conv_tile_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_sched.sv
// Purpose : sequences one 3x3 RGB convolution pass over a tile buffer: pixel load, then window sweep.
// Latency : tile write address appears 1 cycle after a pixel accept; window origin advances 1 cycle after a handshake.
// Backpressure: pix_valid bubbles stall the load; win_ready=0 holds the window origin; abort returns to IDLE.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   start, abort                frame control (start sampled in IDLE only; abort wins over everything)
//   pix_valid / pix_ready       raster pixel stream handshake
//   wr_en, wr_row, wr_col       registered tile-buffer write strobe and address
//   win_valid / win_ready       window origin handshake to the convolution engine
//   win_row, win_col, win_last  window top-left origin, final-window marker
//   busy, done, frame_cnt       status to top-level control
module conv_tile_sched #(
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int K     = 3,
  parameter int AW    = 3
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_row,
  output logic [AW-1:0] wr_col,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [AW-1:0] win_row,
  output logic [AW-1:0] win_col,
  output logic          win_last,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frame_cnt
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX + 1);

  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [AW-1:0] COL_MAX  = AW'(IMG_W - 1);
  localparam logic [AW-1:0] WROW_MAX = AW'(IMG_H - K);
  localparam logic [AW-1:0] WCOL_MAX = AW'(IMG_W - K);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_CONV   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] pix_cnt;
  logic [AW-1:0] pix_row;
  logic [AW-1:0] pix_col;

  logic start_go;
  logic pix_acc;
  logic win_hs;
  logic last_pix;
  logic win_at_last;

  // Qualified events; abort suppresses every side effect in its cycle.
  assign start_go    = (state == S_IDLE) && start && !abort;
  assign pix_acc     = (state == S_LOAD) && pix_valid && !abort;
  assign win_hs      = (state == S_CONV) && win_ready && !abort;
  assign last_pix    = (pix_cnt == PIX_LAST);
  assign win_at_last = (win_row == WROW_MAX) && (win_col == WCOL_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus Moore outputs. Outputs are decoded from the state
  // register only, so pix_valid/win_ready never reach an output combinationally.
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    win_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    win_last  = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        pix_ready = 1'b1;
        if (pix_valid && last_pix) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        state_nxt = S_CONV;
      end
      S_CONV: begin
        win_valid = 1'b1;
        win_last  = win_at_last;
        if (win_ready && win_at_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Pixel raster counter and window origin counter, both column fastest.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_cnt <= '0;
      pix_row <= '0;
      pix_col <= '0;
      win_row <= '0;
      win_col <= '0;
    end else if (start_go) begin
      pix_cnt <= '0;
      pix_row <= '0;
      pix_col <= '0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      if (pix_acc) begin
        pix_cnt <= pix_cnt + PW'(1);
        if (pix_col == COL_MAX) begin
          pix_col <= '0;
          pix_row <= pix_row + AW'(1);
        end else begin
          pix_col <= pix_col + AW'(1);
        end
      end
      if (win_hs) begin
        if (win_col == WCOL_MAX) begin
          win_col <= '0;
          win_row <= (win_row == WROW_MAX) ? '0 : win_row + AW'(1);
        end else begin
          win_col <= win_col + AW'(1);
        end
      end
    end
  end

  // Write strobe is one cycle behind the accept and carries that pixel's address.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_en  <= 1'b0;
      wr_row <= '0;
      wr_col <= '0;
    end else begin
      wr_en <= pix_acc;
      if (pix_acc) begin
        wr_row <= pix_row;
        wr_col <= pix_col;
      end
    end
  end

  // Frame counted as DONE is left; an abort in DONE leaves the count untouched.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= 8'd0;
    end else if ((state == S_DONE) && !abort) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
module tb_conv_tile_sched;

  localparam int AW = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          start;
  logic          abort;
  logic          pix_valid;
  logic          pix_ready;
  logic          wr_en;
  logic [AW-1:0] wr_row;
  logic [AW-1:0] wr_col;
  logic          win_valid;
  logic          win_ready;
  logic [AW-1:0] win_row;
  logic [AW-1:0] win_col;
  logic          win_last;
  logic          busy;
  logic          done;
  logic [7:0]    frame_cnt;

  int checks   = 0;
  int failures = 0;

  conv_tile_sched #(.IMG_W(6), .IMG_H(6), .K(3), .AW(AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge: inputs driven here
  // apply to the new cycle, outputs sampled here belong to it.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_pix_ready"}, int'(pix_ready), 0);
    check_val({tag, "_win_valid"}, int'(win_valid), 0);
    check_val({tag, "_wr_en"}, int'(wr_en), 0);
    check_val({tag, "_done"}, int'(done), 0);
  endtask

  // Wait (bounded) for the done pulse, then step into IDLE.
  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_val({tag, "_done_seen"}, int'(seen), 1);
    step();
  endtask

  // Cycle-exact frame with pix_valid=1 and win_ready=1; cycle 0 is the
  // first cycle after the edge that samples start.
  task automatic nominal_frame(input bit hold_start);
    int  fc0 = int'(frame_cnt);
    bit  exp_wr, exp_win;
    start     = 1'b1;
    pix_valid = 1'b1;
    win_ready = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    for (int c = 0; c <= 54; c++) begin
      exp_wr  = (c >= 1) && (c <= 36);
      exp_win = (c >= 37) && (c <= 52);
      check_val($sformatf("nom_c%0d_pix_ready", c), int'(pix_ready), int'(c <= 35));
      check_val($sformatf("nom_c%0d_wr_en", c), int'(wr_en), int'(exp_wr));
      if (exp_wr) begin
        check_val($sformatf("nom_c%0d_wr_row", c), int'(wr_row), (c - 1) / 6);
        check_val($sformatf("nom_c%0d_wr_col", c), int'(wr_col), (c - 1) % 6);
      end
      check_val($sformatf("nom_c%0d_win_valid", c), int'(win_valid), int'(exp_win));
      if (exp_win) begin
        check_val($sformatf("nom_c%0d_win_row", c), int'(win_row), (c - 37) / 4);
        check_val($sformatf("nom_c%0d_win_col", c), int'(win_col), (c - 37) % 4);
      end
      check_val($sformatf("nom_c%0d_win_last", c), int'(win_last), int'(c == 52));
      check_val($sformatf("nom_c%0d_done", c), int'(done), int'(c == 53));
      check_val($sformatf("nom_c%0d_busy", c), int'(busy), int'(c <= 53));
      if (c < 54) step();
    end
    check_val("nom_frame_cnt", int'(frame_cnt), (fc0 + 1) % 256);
    if (hold_start) begin
      // start was high through LOAD/CONV/DONE without restarting; the
      // IDLE cycle at 54 samples it and loading begins again.
      step();
      check_val("hold_restart_pix_ready", int'(pix_ready), 1);
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_idle("hold_cleanup");
    end
  endtask

  task automatic bubble_frame();
    int  fc0 = int'(frame_cnt);
    int  acc = 0;
    int  nwr = 0;
    bit  last_acc = 1'b0;
    bit  pv;
    start     = 1'b1;
    win_ready = 1'b1;
    pix_valid = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 58; k++) begin
      check_val($sformatf("bub_k%0d_wr_en", k), int'(wr_en), int'(last_acc));
      if (wr_en) begin
        check_val($sformatf("bub_n%0d_wr_row", nwr), int'(wr_row), nwr / 6);
        check_val($sformatf("bub_n%0d_wr_col", nwr), int'(wr_col), nwr % 6);
        nwr++;
      end
      pv        = ((k % 3) != 2);
      pix_valid = pv;
      last_acc  = pv && (acc < 36);
      if (last_acc) acc++;
      step();
    end
    check_val("bub_wr_count", nwr, 36);
    wait_done("bub", 40);
    check_val("bub_frame_cnt", int'(frame_cnt), (fc0 + 1) % 256);
  endtask

  task automatic backpressure_frame();
    int fc0 = int'(frame_cnt);
    bit found = 1'b0;
    start     = 1'b1;
    pix_valid = 1'b1;
    win_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (win_valid && win_row == 3'd1 && win_col == 3'd2) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_val("bp_reach_1_2", int'(found), 1);
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("bp_hold%0d_valid", i), int'(win_valid), 1);
      check_val($sformatf("bp_hold%0d_row", i), int'(win_row), 1);
      check_val($sformatf("bp_hold%0d_col", i), int'(win_col), 2);
      check_val($sformatf("bp_hold%0d_last", i), int'(win_last), 0);
    end
    win_ready = 1'b1;
    step();
    check_val("bp_resume_row", int'(win_row), 1);
    check_val("bp_resume_col", int'(win_col), 3);
    wait_done("bp", 20);
    check_val("bp_frame_cnt", int'(frame_cnt), (fc0 + 1) % 256);
  endtask

  task automatic abort_tests();
    int fc0 = int'(frame_cnt);
    int nwr = 0;
    bit found = 1'b0;
    // Abort in CONV at origin (2,1) with win_ready high.
    start     = 1'b1;
    pix_valid = 1'b1;
    win_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (win_valid && win_row == 3'd2 && win_col == 3'd1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_val("ab_reach_2_1", int'(found), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("ab_conv");
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("ab_conv_nodone%0d", i), int'(done), 0);
    end
    check_val("ab_conv_frame_cnt", int'(frame_cnt), fc0);
    // A following start performs a full load from (0,0).
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wr_en) begin
        check_val($sformatf("ab_re_n%0d_row", nwr), int'(wr_row), nwr / 6);
        check_val($sformatf("ab_re_n%0d_col", nwr), int'(wr_col), nwr % 6);
        nwr++;
      end
      step();
    end
    check_val("ab_reload_count", nwr, 36);
    wait_done("ab_re", 30);
    check_val("ab_re_frame_cnt", int'(frame_cnt), (fc0 + 1) % 256);
    // Abort during LOAD while a pixel is offered.
    fc0   = int'(frame_cnt);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_val("ab_load_wr_active", int'(wr_en), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("ab_load");
    // Abort in IDLE, together with start: nothing happens.
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_idle("ab_idle");
    check_val("ab_idle_frame_cnt", int'(frame_cnt), fc0);
  endtask

  task automatic reset_midframe();
    start     = 1'b1;
    pix_valid = 1'b1;
    win_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_idle("rst_async");
    check_val("rst_async_wr_row", int'(wr_row), 0);
    check_val("rst_async_wr_col", int'(wr_col), 0);
    check_val("rst_async_frame_cnt", int'(frame_cnt), 0);
    check_val("rst_async_win_last", int'(win_last), 0);
    step();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val($sformatf("rst_quiet%0d_busy", i), int'(busy), 0);
      check_val($sformatf("rst_quiet%0d_wr_en", i), int'(wr_en), 0);
      check_val($sformatf("rst_quiet%0d_pix_ready", i), int'(pix_ready), 0);
    end
  endtask

  task automatic wrap_frames();
    int fc_exp = 0;
    for (int f = 0; f < 256; f++) begin
      start     = 1'b1;
      pix_valid = 1'b1;
      win_ready = 1'b1;
      step();
      start = 1'b0;
      wait_done($sformatf("wrap_f%0d", f), 70);
      fc_exp = (fc_exp + 1) % 256;
      if (f == 254) check_val("wrap_255", int'(frame_cnt), fc_exp);
    end
    check_val("wrap_zero", int'(frame_cnt), 0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    step();
    step();
    check_idle("por");
    check_val("por_frame_cnt", int'(frame_cnt), 0);
    check_val("por_win_last", int'(win_last), 0);
    sys_rst_n = 1'b1;
    step();
    check_idle("por_release");

    nominal_frame(1'b0);
    bubble_frame();
    backpressure_frame();
    abort_tests();
    nominal_frame(1'b1);
    reset_midframe();
    wrap_frames();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something above stalls unexpectedly.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
